timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//  8051 Timer 0/1 engine: holds TMOD/TL0/TH0/TL1/TH1 and sequences the counters from the
//  TCON run bits (TR0/TR1). Raises one-clock pulses that the TCON block ORs into TF0/TF1.
//  Sits beside the TCON SFR on the SFR write bus. Feeds the interrupt controller and UART baud logic.
// PARAMETERS
//  PRESCALE  12  clocks per machine cycle (timer tick period); legal range 2..255
// PORTS
//  clock      in   1  system clock; reset reset, asynchronous, active-high; clock clock
//  reset      in   1  async active-high reset
//  data_in    in   8  SFR write data
//  addr       in   8  SFR byte address (or bit address when wr_bit_en)
//  wr_en      in   1  SFR write strobe
//  wr_bit_en  in   1  bit-write qualifier; this block ignores bit writes (none of its SFRs is bit-addressable)
//  tcon_data  in   8  current TCON: [6]=TR1, [4]=TR0 used
//  t0_pin     in   1  external count input T0 (async)
//  t1_pin     in   1  external count input T1 (async)
//  int0_n     in   1  /INT0 pin (async), used for GATE0
//  int1_n     in   1  /INT1 pin (async), used for GATE1
//  tmod_data  out  8  TMOD register
//  tl0_data   out  8  TL0;   th0_data out 8 TH0
//  tl1_data   out  8  TL1;   th1_data out 8 TH1
//  tf0_set    out  1  1-clock pulse: timer0 (or TL0 in mode 3) overflowed
//  tf1_set    out  1  1-clock pulse: timer1 overflowed, or TH0 overflowed in mode 3
//  t1_ovf     out  1  1-clock pulse on every timer1 overflow, incl. while T0 is in mode 3 (baud source)
// BEHAVIOUR
//  Reset: all registers 0, prescaler 0, synchronizers 1 (pins idle high), all pulse outputs 0.
//  Byte writes (wr_en & !wr_bit_en) decode on addr:
//   `SFR_TMOD 0x89, `SFR_TL0 0x8A, `SFR_TL1 0x8B, `SFR_TH0 0x8C, `SFR_TH1 0x8D.
//  TMOD fields:
//   [7] GATE1   [6] C/T1   [5:4] M1
//   [3] GATE0   [2] C/T0   [1:0] M0
//  Prescaler counts 0..PRESCALE-1 and wraps; tick = (count==PRESCALE-1). Free-running, never stopped.
//  Pins: 2-flop synchronizer per pin. Counter event = synced T pin sampled 1 at prev tick, 0 at this tick.
//  Increment enable per timer x:
//   inc_x = tick & TRx & (!GATEx | int_x_n_sync) & (C/Tx ? fall_x : 1).
//  Modes, per timer:
//   M=0  13-bit: TL[4:0] counts; carry into TH; TL[7:5] hold their value.
//        Overflow when TH==FF & TL[4:0]==1F; both wrap to 0.
//   M=1  16-bit TH:TL. Overflow at FFFF -> 0000.
//   M=2  8-bit auto-reload: TL counts; on TL==FF, TL<=TH and overflow pulses.
//   M=3  timer0 only. TL0 = 8-bit under TR0/GATE0/C/T0, overflow -> tf0_set.
//        TH0 = 8-bit timer (clock ticks only) under TR1, overflow -> tf1_set.
//        Timer1 set to M=3 holds its count: no increment, no pulse.
//  While M0=3, timer1 keeps running in modes 0-2 but does not drive tf1_set; it still drives t1_ovf.
//  Latency: register updates on the clock edge where tick=1; tf*_set/t1_ovf high for that same next cycle only.
//  Collision: SFR write to a byte in the same cycle as its increment -> written value wins, increment of that byte lost.
//   Carry into an unwritten byte still applies; no overflow pulse is generated that cycle for that timer.
//  TMOD write takes effect on the next tick; an in-flight count is not cleared.
//  TR cleared mid-count: count freezes at its current value and resumes on re-set.
//  Reset mid-operation: immediate return to reset state, pulses dropped.
// STRUCTURE
//  Shared package/include (define_opcodes.v): SFR addresses above;
//  TMOD field indices; TCON bit indices TR0=4, TF0=5, TR1=6, TF1=7; mode codes 2'd0..2'd3.
//  One natural sub-module: timer_cnt8x2.
//   Contents: one TH/TL pair with mode 0/1/2 logic, write port, inc in, ovf out.
//   Instantiated twice.
//  Mode-3 split and the sync/prescale logic live in the top.
// TESTING
//  1. PRESCALE=12, TMOD=01, TL0=FE, TH0=FF, TR0=1 -> 0000 after 24 clocks; tf0_set pulses once at 2nd tick.
//  2. TMOD=20, TH1=F3, TL1=FF, TR1=1 -> tick1 TL1=F3 + t1_ovf/tf1_set pulse; then every 13 ticks.
//  3. TMOD=05 (counter, M1), TR0=1; 3 falling edges on t0_pin (each held >=2 ticks) -> TL0=03; no change while pin static.
//  4. TMOD=09 (GATE0), TR0=1, int0_n=0 -> TL0 frozen; int0_n=1 -> counts each tick.
//  5. TMOD=03, TL0=FF, TH0=FF, TR0=1, TR1=1, next tick -> tf0_set and tf1_set both pulse; TL1/TH1 unchanged if M1=3.
//  6. Write TL0=55 in the cycle of a tick with TR0=1, M=1, TL0=FF -> TL0=55, TH0 incremented, no tf0_set; assert reset -> all outputs 0.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the 8051 timer 0/1 engine: SFR byte addresses,
// TMOD/TCON field positions and the per-timer mode encoding.
package timer_ctrl_pkg;

  localparam logic [7:0] SFR_TMOD = 8'h89;
  localparam logic [7:0] SFR_TL0  = 8'h8A;
  localparam logic [7:0] SFR_TL1  = 8'h8B;
  localparam logic [7:0] SFR_TH0  = 8'h8C;
  localparam logic [7:0] SFR_TH1  = 8'h8D;

  // TMOD field positions (mode fields are 2 bits wide starting at the LSB given)
  localparam int unsigned TMOD_GATE1 = 7;
  localparam int unsigned TMOD_CT1   = 6;
  localparam int unsigned TMOD_M1    = 4;
  localparam int unsigned TMOD_GATE0 = 3;
  localparam int unsigned TMOD_CT0   = 2;
  localparam int unsigned TMOD_M0    = 0;

  // TCON run bits
  localparam int unsigned TCON_TR0 = 4;
  localparam int unsigned TCON_TR1 = 6;

  typedef enum logic [1:0] {
    MODE_13BIT  = 2'd0,
    MODE_16BIT  = 2'd1,
    MODE_RELOAD = 2'd2,
    MODE_SPLIT  = 2'd3
  } timer_mode_t;

  function automatic timer_mode_t to_mode(input logic [1:0] m);
    return timer_mode_t'(m);
  endfunction

endpackage

// File: rtl/timer_cnt8x2.sv
// One TH/TL counter pair with 13-bit, 16-bit and 8-bit auto-reload modes.
// Mode 3 holds the count; the split behaviour of timer 0 is built by the
// parent through the byte write ports.
module timer_cnt8x2
  import timer_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       inc,
  input  logic       tl_we,
  input  logic       th_we,
  input  logic [7:0] tl_wdata,
  input  logic [7:0] th_wdata,
  output logic [7:0] tl,
  output logic [7:0] th,
  output logic       ovf
);

  timer_mode_t mode_e;
  logic [7:0]  tl_nxt;
  logic [7:0]  th_nxt;
  logic        ovf_cnt;

  assign mode_e = to_mode(mode);

  // Next count per mode; a byte write overrides that byte only, and any
  // write to the pair cancels the overflow for this cycle.
  always_comb begin
    tl_nxt  = tl;
    th_nxt  = th;
    ovf_cnt = 1'b0;
    if (inc) begin
      case (mode_e)
        MODE_13BIT: begin
          tl_nxt = {tl[7:5], tl[4:0] + 5'd1};
          if (tl[4:0] == 5'h1F) begin
            th_nxt  = th + 8'd1;
            ovf_cnt = (th == 8'hFF);
          end
        end
        MODE_16BIT: begin
          tl_nxt = tl + 8'd1;
          if (tl == 8'hFF) begin
            th_nxt  = th + 8'd1;
            ovf_cnt = (th == 8'hFF);
          end
        end
        MODE_RELOAD: begin
          if (tl == 8'hFF) begin
            tl_nxt  = th;
            ovf_cnt = 1'b1;
          end else begin
            tl_nxt = tl + 8'd1;
          end
        end
        default: ;
      endcase
    end
    if (tl_we) tl_nxt = tl_wdata;
    if (th_we) th_nxt = th_wdata;
    ovf = ovf_cnt & ~(tl_we | th_we);
  end

  // Count registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tl <= '0;
      th <= '0;
    end else begin
      tl <= tl_nxt;
      th <= th_nxt;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// 8051 Timer 0/1 engine: TMOD and the TL/TH registers, machine-cycle
// prescaler, pin synchronizers, gate/counter qualification, the timer 0
// mode-3 split, and registered one-clock overflow pulses.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 12
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic       wr_bit_en,
  input  logic [7:0] tcon_data,
  input  logic       t0_pin,
  input  logic       t1_pin,
  input  logic       int0_n,
  input  logic       int1_n,
  output logic [7:0] tmod_data,
  output logic [7:0] tl0_data,
  output logic [7:0] th0_data,
  output logic [7:0] tl1_data,
  output logic [7:0] th1_data,
  output logic       tf0_set,
  output logic       tf1_set,
  output logic       t1_ovf
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0] pre_cnt;
  logic       tick;
  logic [7:0] tmod_q;
  logic [3:0] sync1, sync2;   // {int1_n, int0_n, t1_pin, t0_pin}
  logic [1:0] t_prev;         // T pins as seen at the previous tick
  logic       fall0, fall1;
  logic       byte_wr, wr_tmod, wr_tl0, wr_th0, wr_tl1, wr_th1;
  logic       inc0, inc1, split;
  logic       tl0_split_inc, th0_split_inc;
  logic       t0_tl_we, t0_th_we;
  logic [7:0] t0_tl_wd, t0_th_wd;
  logic       t0_cnt_ovf, t1_cnt_ovf;
  logic       tf0_raw, tf1_raw;
  logic       unused_tcon;

  assign unused_tcon = ^{tcon_data[7], tcon_data[5], tcon_data[3:0]};

  assign tick = (pre_cnt == PRE_LAST);

  // Free-running machine-cycle prescaler
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 8'd1;
  end

  // Two-flop synchronizers (idle high) and per-tick T pin history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      t_prev <= '1;
    end else begin
      sync1 <= {int1_n, int0_n, t1_pin, t0_pin};
      sync2 <= sync1;
      if (tick) t_prev <= sync2[1:0];
    end
  end

  assign fall0 = t_prev[0] & ~sync2[0];
  assign fall1 = t_prev[1] & ~sync2[1];

  assign byte_wr = wr_en & ~wr_bit_en;
  assign wr_tmod = byte_wr & (addr == SFR_TMOD);
  assign wr_tl0  = byte_wr & (addr == SFR_TL0);
  assign wr_th0  = byte_wr & (addr == SFR_TH0);
  assign wr_tl1  = byte_wr & (addr == SFR_TL1);
  assign wr_th1  = byte_wr & (addr == SFR_TH1);

  // TMOD register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        tmod_q <= '0;
    else if (wr_tmod) tmod_q <= data_in;
  end

  assign tmod_data = tmod_q;

  assign inc0 = tick & tcon_data[TCON_TR0] & (~tmod_q[TMOD_GATE0] | sync2[2])
              & (tmod_q[TMOD_CT0] ? fall0 : 1'b1);
  assign inc1 = tick & tcon_data[TCON_TR1] & (~tmod_q[TMOD_GATE1] | sync2[3])
              & (tmod_q[TMOD_CT1] ? fall1 : 1'b1);

  // Mode-3 split: the pair is held in mode 3, so TL0 and TH0 are advanced
  // through the write ports instead, with SFR writes taking priority.
  assign split         = (to_mode(tmod_q[TMOD_M0 +: 2]) == MODE_SPLIT);
  assign tl0_split_inc = split & inc0;
  assign th0_split_inc = split & tick & tcon_data[TCON_TR1];
  assign t0_tl_we      = wr_tl0 | tl0_split_inc;
  assign t0_th_we      = wr_th0 | th0_split_inc;
  assign t0_tl_wd      = wr_tl0 ? data_in : tl0_data + 8'd1;
  assign t0_th_wd      = wr_th0 ? data_in : th0_data + 8'd1;

  timer_cnt8x2 u_timer0 (
    .clock    (clock),
    .reset    (reset),
    .mode     (tmod_q[TMOD_M0 +: 2]),
    .inc      (inc0),
    .tl_we    (t0_tl_we),
    .th_we    (t0_th_we),
    .tl_wdata (t0_tl_wd),
    .th_wdata (t0_th_wd),
    .tl       (tl0_data),
    .th       (th0_data),
    .ovf      (t0_cnt_ovf)
  );

  timer_cnt8x2 u_timer1 (
    .clock    (clock),
    .reset    (reset),
    .mode     (tmod_q[TMOD_M1 +: 2]),
    .inc      (inc1),
    .tl_we    (wr_tl1),
    .th_we    (wr_th1),
    .tl_wdata (data_in),
    .th_wdata (data_in),
    .tl       (tl1_data),
    .th       (th1_data),
    .ovf      (t1_cnt_ovf)
  );

  assign tf0_raw = split ? (tl0_split_inc & ~wr_tl0 & (tl0_data == 8'hFF)) : t0_cnt_ovf;
  assign tf1_raw = split ? (th0_split_inc & ~wr_th0 & (th0_data == 8'hFF)) : t1_cnt_ovf;

  // One-clock overflow pulses, aligned with the updated count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tf0_set <= 1'b0;
      tf1_set <= 1'b0;
      t1_ovf  <= 1'b0;
    end else begin
      tf0_set <= tf0_raw;
      tf1_set <= tf1_raw;
      t1_ovf  <= t1_cnt_ovf;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: stimulus queues expected snapshots,
// a negedge monitor pops one whenever a pulse appears or a check is requested.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic [7:0] addr = '0;
  logic       wr_en = 1'b0;
  logic       wr_bit_en = 1'b0;
  logic [7:0] tcon_data = '0;
  logic       t0_pin = 1'b1;
  logic       t1_pin = 1'b1;
  logic       int0_n = 1'b1;
  logic       int1_n = 1'b1;
  logic [7:0] tmod_data, tl0_data, th0_data, tl1_data, th1_data;
  logic       tf0_set, tf1_set, t1_ovf;

  always #5 clock = ~clock;

  timer_ctrl #(.PRESCALE(12)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .addr(addr),
    .wr_en(wr_en), .wr_bit_en(wr_bit_en), .tcon_data(tcon_data),
    .t0_pin(t0_pin), .t1_pin(t1_pin), .int0_n(int0_n), .int1_n(int1_n),
    .tmod_data(tmod_data), .tl0_data(tl0_data), .th0_data(th0_data),
    .tl1_data(tl1_data), .th1_data(th1_data),
    .tf0_set(tf0_set), .tf1_set(tf1_set), .t1_ovf(t1_ovf)
  );

  typedef struct {
    string      name;
    logic [2:0] p;      // {tf0_set, tf1_set, t1_ovf}
    logic [7:0] tmod, tl0, th0, tl1, th1;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk = 1'b0;
  int   pre_m;

  // Reference machine-cycle phase: a tick edge follows pre_m == 11
  always @(posedge clock or posedge reset) begin
    if (reset) pre_m <= 0;
    else       pre_m <= (pre_m == 11) ? 0 : pre_m + 1;
  end

  function automatic string fmt(input logic [42:0] v);
    return $sformatf("p=%b tmod=%h tl0=%h th0=%h tl1=%h th1=%h",
                     v[42:40], v[39:32], v[31:24], v[23:16], v[15:8], v[7:0]);
  endfunction

  logic [42:0] mon_act, mon_req;
  exp_t        mon_e;

  // Monitor
  always @(negedge clock) begin
    if (chk || tf0_set || tf1_set || t1_ovf) begin
      n_tests++;
      mon_act = {tf0_set, tf1_set, t1_ovf, tmod_data, tl0_data, th0_data, tl1_data, th1_data};
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: actual %s, required no event", fmt(mon_act));
      end else begin
        mon_e   = sb_q.pop_front();
        mon_req = {mon_e.p, mon_e.tmod, mon_e.tl0, mon_e.th0, mon_e.tl1, mon_e.th1};
        if (mon_act !== mon_req) begin
          n_fail++;
          $display("FAIL %s: actual %s, required %s", mon_e.name, fmt(mon_act), fmt(mon_req));
        end
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_pre_last();
    int i = 0;
    @(negedge clock);
    while (pre_m != 11 && i < 40) begin
      @(negedge clock);
      i++;
    end
    if (pre_m != 11) begin
      n_tests++; n_fail++;
      $display("FAIL tick_timeout: actual no tick in 40 clocks, required tick every 12");
    end
  endtask

  // Return 1ns after the next tick edge
  task automatic next_tick();
    wait_pre_last();
    @(posedge clock); #1;
  endtask

  task automatic wr_at_tick(input logic [7:0] a, input logic [7:0] d);
    wait_pre_last();
    addr = a; data_in = d; wr_en = 1'b1;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic chk_now(input string name, input logic [2:0] p, input logic [7:0] tm,
                         input logic [7:0] l0, input logic [7:0] h0,
                         input logic [7:0] l1, input logic [7:0] h1);
    exp_t e;
    e.name = name; e.p = p; e.tmod = tm;
    e.tl0 = l0; e.th0 = h0; e.tl1 = l1; e.th1 = h1;
    sb_q.push_back(e);
    chk = 1'b1;
    @(negedge clock); #1;
    chk = 1'b0;
  endtask

  task automatic tick_chk(input string name, input logic [2:0] p, input logic [7:0] tm,
                          input logic [7:0] l0, input logic [7:0] h0,
                          input logic [7:0] l1, input logic [7:0] h1);
    next_tick();
    chk_now(name, p, tm, l0, h0, l1, h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual bench still running, required completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_now("reset_state", 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    next_tick();

    // 1: mode 1 overflow FFFE -> FFFF -> 0000
    wr(SFR_TMOD, 8'h01); wr(SFR_TL0, 8'hFE); wr(SFR_TH0, 8'hFF);
    tcon_data = 8'h10;
    tick_chk("m1_tick1", 3'b000, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00);
    tick_chk("m1_ovf",   3'b100, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    tick_chk("m1_tick3", 3'b000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);

    // 2: timer1 auto-reload, period 13 ticks
    tcon_data = 8'h00;
    wr(SFR_TMOD, 8'h20); wr(SFR_TH1, 8'hF3); wr(SFR_TL1, 8'hFF);
    tcon_data = 8'h40;
    tick_chk("m2_reload1", 3'b011, 8'h20, 8'h01, 8'h00, 8'hF3, 8'hF3);
    for (int i = 0; i < 11; i++) next_tick();
    tick_chk("m2_tick13",  3'b000, 8'h20, 8'h01, 8'h00, 8'hFF, 8'hF3);
    tick_chk("m2_reload2", 3'b011, 8'h20, 8'h01, 8'h00, 8'hF3, 8'hF3);

    // 3: counter mode on falling T0 edges
    tcon_data = 8'h00;
    wr(SFR_TMOD, 8'h05); wr(SFR_TL0, 8'h00); wr(SFR_TH0, 8'h00);
    tcon_data = 8'h10;
    for (int k = 0; k < 3; k++) begin
      t0_pin = 1'b0;
      tick_chk($sformatf("cnt_fall%0d", k), 3'b000, 8'h05, 8'(k + 1), 8'h00, 8'hF3, 8'hF3);
      next_tick();
      t0_pin = 1'b1;
      next_tick();
      next_tick();
    end
    tick_chk("cnt_static", 3'b000, 8'h05, 8'h03, 8'h00, 8'hF3, 8'hF3);

    // 4: GATE0 with /INT0
    tcon_data = 8'h00;
    int0_n = 1'b0;
    wr(SFR_TMOD, 8'h09); wr(SFR_TL0, 8'h00);
    tcon_data = 8'h10;
    tick_chk("gate_low_a",  3'b000, 8'h09, 8'h00, 8'h00, 8'hF3, 8'hF3);
    tick_chk("gate_low_b",  3'b000, 8'h09, 8'h00, 8'h00, 8'hF3, 8'hF3);
    int0_n = 1'b1;
    tick_chk("gate_high_a", 3'b000, 8'h09, 8'h01, 8'h00, 8'hF3, 8'hF3);
    tick_chk("gate_high_b", 3'b000, 8'h09, 8'h02, 8'h00, 8'hF3, 8'hF3);

    // 5: timer0 split mode; timer1 held in mode 3
    tcon_data = 8'h00;
    wr(SFR_TMOD, 8'h33); wr(SFR_TL0, 8'hFF); wr(SFR_TH0, 8'hFF);
    wr(SFR_TL1, 8'h12); wr(SFR_TH1, 8'h34);
    tcon_data = 8'h50;
    tick_chk("split_ovf",  3'b110, 8'h33, 8'h00, 8'h00, 8'h12, 8'h34);
    tick_chk("split_next", 3'b000, 8'h33, 8'h01, 8'h01, 8'h12, 8'h34);
    // timer1 in mode 2 beside split timer0: t1_ovf only
    tcon_data = 8'h00;
    wr(SFR_TMOD, 8'h23); wr(SFR_TL0, 8'h10); wr(SFR_TH0, 8'h20);
    wr(SFR_TL1, 8'hFF); wr(SFR_TH1, 8'h80);
    tcon_data = 8'h50;
    tick_chk("split_t1_baud", 3'b001, 8'h23, 8'h11, 8'h21, 8'h80, 8'h80);
    tick_chk("split_t1_next", 3'b000, 8'h23, 8'h12, 8'h22, 8'h81, 8'h80);

    // 6: write/increment collision at an overflow point, then reset
    tcon_data = 8'h00;
    wr(SFR_TMOD, 8'h01); wr(SFR_TL0, 8'hFF); wr(SFR_TH0, 8'hFF);
    tcon_data = 8'h10;
    wr_at_tick(SFR_TL0, 8'h55);
    chk_now("collision", 3'b000, 8'h01, 8'h55, 8'h00, 8'h81, 8'h80);
    tick_chk("post_collision", 3'b000, 8'h01, 8'h56, 8'h00, 8'h81, 8'h80);
    reset = 1'b1;
    chk_now("reset_mid_run", 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    tick_chk("resume_mode0", 3'b000, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);

    next_tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
